// File: rtl/seqdet_stepper.sv
// seqdet_stepper: paces a programmed bit pattern into the 0110 detector and counts its hits
module seqdet_stepper #(
  parameter int DIV = 20000000,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             step,
  input  logic [15:0]      pat,
  input  logic [3:0]       len,
  input  logic             y,
  output logic             x,
  output logic             step_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hits,
  output logic [3:0]       bit_idx
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [2:0] {IDLE, WAIT, DRIVE, SAMPLE, FINISH} state_t;
  state_t      state;
  logic [PW-1:0] pre;
  logic        step_q, mode_q;
  logic [15:0] pat_q;
  logic [3:0]  len_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      x       <= 1'b1;
      step_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hits    <= '0;
      bit_idx <= '0;
      pre     <= '0;
      step_q  <= 1'b0;
      mode_q  <= 1'b0;
      pat_q   <= '0;
      len_q   <= '0;
    end else begin
      step_q  <= step;
      step_en <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: if (start) begin
          pat_q   <= pat;
          len_q   <= len;
          mode_q  <= mode;
          hits    <= '0;
          bit_idx <= '0;
          pre     <= '0;
          x       <= pat[0];
          busy    <= 1'b1;
          state   <= WAIT;
        end
        WAIT: if (!mode_q) begin
          if (pre == PW'(DIV - 1)) begin
            pre     <= '0;
            step_en <= 1'b1;
            state   <= DRIVE;
          end else begin
            pre <= pre + 1'b1;
          end
        end else if (step && !step_q) begin
          step_en <= 1'b1;
          state   <= DRIVE;
        end
        DRIVE: state <= SAMPLE;
        SAMPLE: begin
          if (!y && hits != {CNT_W{1'b1}}) hits <= hits + 1'b1;
          if (bit_idx == len_q) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            x     <= 1'b1;
            state <= FINISH;
          end else begin
            bit_idx <= bit_idx + 4'd1;
            x       <= pat_q[bit_idx + 4'd1];
            state   <= WAIT;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seqdet_stepper.sv
// tb_seqdet_stepper: random and directed stimulus checked every cycle against a timeline model
module tb_seqdet_stepper;
  localparam int DIV = 4, CNT_W = 2, HMAX = (1 << CNT_W) - 1;
  logic clk = 0, rst = 1, start = 0, mode = 0, step = 0, y = 1;
  logic [15:0] pat = '0;
  logic [3:0] len = '0;
  logic x, step_en, busy, done;
  logic [CNT_W-1:0] hits;
  logic [3:0] bit_idx;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  seqdet_stepper #(.DIV(DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .step(step), .pat(pat), .len(len),
    .y(y), .x(x), .step_en(step_en), .busy(busy), .done(done), .hits(hits), .bit_idx(bit_idx)
  );
  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // Model: each run is a timeline of drive cycles; free-run drives are DIV cycles after
  // each wait opens, single-step drives follow the first step edge seen after it opens.
  int cyc = 0, k = 0, m_len = 0, wait_start = 0, drive_at = -10, idle_from = 0;
  int run0 = 0, done_rel = -1, e_hits = 0, e_idx = 0;
  bit armed = 0, active = 0, m_mode = 0, prev_step = 0;
  bit e_x = 1, e_se = 0, e_busy = 0, e_done = 0;
  logic [15:0] m_pat = '0;
  int se_q[$];
  bit xq[$];
  always @(negedge clk) begin
    if (armed) begin
      chk("x", x, e_x);
      chk("step_en", step_en, e_se);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("hits", hits, e_hits);
      chk("bit_idx", bit_idx, e_idx);
    end
    if (step_en) begin
      se_q.push_back(cyc - run0);
      xq.push_back(x);
    end
    if (done) done_rel = cyc - run0;
    e_se = 0;
    e_done = 0;
    if (rst) begin
      active = 0; e_x = 1; e_busy = 0; e_hits = 0; e_idx = 0;
      drive_at = -10; idle_from = cyc + 1; armed = 1; prev_step = 0;
    end else begin
      if (!active && cyc >= idle_from && start) begin
        m_pat = pat; m_len = len; m_mode = mode; active = 1; k = 0;
        e_hits = 0; e_idx = 0; e_x = pat[0]; e_busy = 1;
        run0 = cyc + 1; wait_start = cyc + 1;
        drive_at = mode ? -10 : cyc + 1 + DIV;
      end else if (active) begin
        if (m_mode && drive_at < 0 && cyc >= wait_start && step && !prev_step) drive_at = cyc + 1;
        if (drive_at >= 0 && cyc + 1 == drive_at) e_se = 1;
        if (drive_at >= 0 && cyc == drive_at + 1) begin
          if (!y && e_hits < HMAX) e_hits++;
          if (k == m_len) begin
            e_done = 1; e_busy = 0; e_x = 1; active = 0; idle_from = cyc + 2; drive_at = -10;
          end else begin
            k++; e_idx = k; e_x = m_pat[k]; wait_start = cyc + 1;
            drive_at = m_mode ? -10 : cyc + 1 + DIV;
          end
        end
      end
      prev_step = step;
    end
    cyc++;
  end
  task automatic clear_log();
    se_q.delete();
    xq.delete();
    done_rel = -1;
  endtask
  initial begin
    rst = 1;
    tick(2);
    rst = 0;
    tick(3);
    chk("rst_x", x, 1);
    chk("rst_busy", busy, 0);
    chk("rst_step_en", step_en, 0);
    chk("rst_done", done, 0);
    chk("rst_hits", hits, 0);
    chk("rst_bit_idx", bit_idx, 0);
    // free-run 0110 with one hit, plus ignored start/step/pat/mode changes mid-run
    clear_log();
    pat = 16'h0006; len = 4'd3; mode = 0; start = 1;
    tick();
    start = 0;
    for (int n = 0; n < 30; n++) begin
      y = (n == 23) ? 1'b0 : 1'b1;
      if (n == 5) pat = 16'hFFFF;
      mode = (n > 3);
      start = (n == 8);
      step = n[1];
      tick();
    end
    y = 1; mode = 0; step = 0;
    chk("fr_pulses", se_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fr_se%0d", i), i < se_q.size() ? se_q[i] : -1, 4 + 6 * i);
      chk($sformatf("fr_x%0d", i), i < xq.size() ? int'(xq[i]) : -1, (6 >> i) & 1);
    end
    chk("fr_done", done_rel, 24);
    chk("fr_hits", hits, 1);
    // single-step with step already high at start
    clear_log();
    step = 1; mode = 1; len = 4'd1; pat = 16'($urandom); start = 1;
    tick();
    start = 0; mode = 0;
    tick(10);
    chk("ss_hold", se_q.size(), 0);
    step = 0;
    tick();
    step = 1;
    tick();
    step = 0;
    tick(4);
    chk("ss_one", se_q.size(), 1);
    step = 1;
    tick(6);
    chk("ss_two", se_q.size(), 2);
    chk("ss_done", done_rel, 19);
    step = 0;
    // saturation over a full 16-bit run
    clear_log();
    y = 0; len = 4'd15; mode = 0; pat = 16'($urandom); start = 1;
    tick();
    start = 0;
    tick(100);
    chk("sat_hits", hits, 3);
    chk("sat_done", done_rel, 96);
    // reset during the DRIVE of bit 2
    clear_log();
    len = 4'd5; start = 1;
    tick();
    start = 0;
    tick(16);
    chk("mr_drive", step_en, 1);
    chk("mr_hits_pre", hits, 2);
    rst = 1;
    tick();
    chk("mr_step_en", step_en, 0);
    chk("mr_busy", busy, 0);
    chk("mr_hits", hits, 0);
    chk("mr_x", x, 1);
    rst = 0; y = 1;
    done_rel = -1;
    tick(40);
    chk("mr_nodone", done_rel, -1);
    // random traffic, model compares every cycle
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 15) == 0);
      mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) step = ~step;
      pat = 16'($urandom);
      len = 4'($urandom);
      y = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 0;
    start = 0;
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
